// File: rtl/sr_stack_ctrl.sv
// Hardware-stack sequencer: arbitrates CPU push/pop and a low-priority debug read onto one sync RAM port.
// Optional macro SR_STACK_CLEAR_EN adds a cpu_clear input that empties the stack and clears error flags.
module sr_stack_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef SR_STACK_CLEAR_EN
  input  logic          cpu_clear,
`endif
  input  logic          cpu_push,
  input  logic          cpu_pop,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          cpu_done,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data,
  output logic          dbg_ack,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          err_ovf,
  output logic          err_udf,
  output logic          err_cmd
);

  // CMD_DONE is the done-only cycle used for rejected push&pop and for clear
  typedef enum logic [2:0] {
    IDLE, PUSH, POP_RD, POP_WB, DBG_RD, DBG_WB, CMD_DONE
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_t      stateReg, stateNext;
  logic [AW:0] spReg, spNext;
  logic [31:0] rdataReg, dbgReg;
  logic        ovfReg, ovfNext;
  logic        udfReg, udfNext;
  logic        cmdReg, cmdNext;
  logic        clearReq;
  logic [AW:0] spMinus1;
  logic [31:0] popData;

`ifdef SR_STACK_CLEAR_EN
  assign clearReq = cpu_clear;
`else
  assign clearReq = 1'b0;
`endif

  assign count    = spReg;
  assign full     = (spReg == FULL_CNT);
  assign empty    = (spReg == '0);
  assign err_ovf  = ovfReg;
  assign err_udf  = udfReg;
  assign err_cmd  = cmdReg;
  assign spMinus1 = spReg - ONE;
  assign popData  = empty ? 32'd0 : ram_rdata;

  // Read data is forwarded in the completion cycle, then held in a register
  assign cpu_rdata = (stateReg == POP_WB) ? popData   : rdataReg;
  assign dbg_data  = (stateReg == DBG_WB) ? ram_rdata : dbgReg;

  // Gated by rst_n so the stall output reads 0 while reset is asserted
  assign cpu_stall = rst_n & (cpu_push | cpu_pop | clearReq) & ~cpu_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      spReg    <= '0;
      rdataReg <= '0;
      dbgReg   <= '0;
      ovfReg   <= 1'b0;
      udfReg   <= 1'b0;
      cmdReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      spReg    <= spNext;
      ovfReg   <= ovfNext;
      udfReg   <= udfNext;
      cmdReg   <= cmdNext;
      if (stateReg == POP_WB) rdataReg <= popData;
      if (stateReg == DBG_WB) dbgReg   <= ram_rdata;
    end
  end

  always_comb begin
    stateNext = stateReg;
    spNext    = spReg;
    ovfNext   = ovfReg;
    udfNext   = udfReg;
    cmdNext   = cmdReg;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    cpu_done  = 1'b0;
    dbg_ack   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (clearReq) begin
          spNext    = '0;
          ovfNext   = 1'b0;
          udfNext   = 1'b0;
          cmdNext   = 1'b0;
          stateNext = CMD_DONE;
        end else if (cpu_push && cpu_pop) begin
          cmdNext   = 1'b1;
          stateNext = CMD_DONE;
        end else if (cpu_push) begin
          stateNext = PUSH;
        end else if (cpu_pop) begin
          stateNext = POP_RD;
        end else if (dbg_req) begin
          stateNext = DBG_RD;
        end
      end
      PUSH: begin
        cpu_done = 1'b1;
        if (!full) begin
          ram_we    = 1'b1;
          ram_addr  = spReg[AW-1:0];
          ram_wdata = cpu_wdata;
          spNext    = spReg + ONE;
        end else begin
          ovfNext = 1'b1;
        end
        stateNext = IDLE;
      end
      POP_RD: begin
        if (!empty) ram_addr = spMinus1[AW-1:0];
        stateNext = POP_WB;
      end
      POP_WB: begin
        cpu_done = 1'b1;
        if (!empty) spNext  = spMinus1;
        else        udfNext = 1'b1;
        stateNext = IDLE;
      end
      DBG_RD: begin
        ram_addr  = dbg_addr;
        stateNext = DBG_WB;
      end
      DBG_WB: begin
        dbg_ack   = 1'b1;
        stateNext = IDLE;
      end
      CMD_DONE: begin
        cpu_done  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
